// File: rtl/pcs_40g_pkg.sv
// Shared constants and state type for the 40G PCS transmit scheduler.
package pcs_40g_pkg;

  localparam int HEAD_W          = 2;
  localparam int DATA_W          = 64;
  localparam int SEQ_MAX         = DATA_W / HEAD_W;
  localparam int AM_PERIOD       = 16384;
  localparam int AM_SHORT_PERIOD = 8;

  typedef enum logic [1:0] {
    WAIT_EN,
    DATA,
    AM
  } sched_state_e;

endpackage

// File: rtl/pcs_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear.
module pcs_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pcs_40g_tx_sched.sv
// 40G PCS transmit scheduler: gearbox sequence, AM period and MAC back-pressure.
// Define PCS_40G_AM_SHORT_PERIOD_EN to use AM_SHORT_PERIOD as the marker period.
module pcs_40g_tx_sched #(
  parameter int DATA_W          = 64,
  parameter int HEAD_W          = pcs_40g_pkg::HEAD_W,
  parameter int SEQ_MAX         = DATA_W / HEAD_W,
  parameter int AM_PERIOD       = pcs_40g_pkg::AM_PERIOD,
  parameter int AM_SHORT_PERIOD = pcs_40g_pkg::AM_SHORT_PERIOD,
  parameter int PIPE_LAT        = 2,
  parameter int SEQ_W           = $clog2(SEQ_MAX + 1),
  parameter int AM_CNT_W        = $clog2((AM_PERIOD > AM_SHORT_PERIOD) ? AM_PERIOD : AM_SHORT_PERIOD)
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                tx_en_i,
  output logic                ready_o,
  output logic [SEQ_W-1:0]    seq_o,
  output logic                gb_pause_o,
  output logic                am_v_o,
  output logic [AM_CNT_W-1:0] am_cnt_o
);

  import pcs_40g_pkg::*;

`ifdef PCS_40G_AM_SHORT_PERIOD_EN
  localparam int AM_EFF = AM_SHORT_PERIOD;
`else
  localparam int AM_EFF = AM_PERIOD;
`endif

  localparam logic [SEQ_W-1:0]    SEQ_LAST = SEQ_W'(SEQ_MAX);
  localparam logic [AM_CNT_W-1:0] CNT_LAST = AM_CNT_W'(AM_EFF - 2);

  sched_state_e          state_q, state_n;
  logic [SEQ_W-1:0]      seq_q, seq_n;
  logic [AM_CNT_W-1:0]   am_cnt_q, am_cnt_n;
  logic                  am_owed_q, am_owed_n;
  logic                  ready_q;
  logic                  seq_last;
  logic                  pause_early;
  logic                  am_early;
  logic [SEQ_W+1:0]      dl_out;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= WAIT_EN;
      seq_q     <= '0;
      am_cnt_q  <= '0;
      am_owed_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      seq_q     <= seq_n;
      am_cnt_q  <= am_cnt_n;
      am_owed_q <= am_owed_n;
      // Precomputed from next state so ready_o comes straight from a flop
      ready_q   <= (state_n == DATA) && (seq_n != SEQ_LAST);
    end
  end

  always_comb begin
    seq_last    = (seq_q == SEQ_LAST);
    state_n     = state_q;
    seq_n       = seq_q;
    am_cnt_n    = am_cnt_q;
    am_owed_n   = am_owed_q;
    pause_early = 1'b0;
    am_early    = 1'b0;

    case (state_q)
      WAIT_EN: begin
        if (tx_en_i) state_n = am_owed_q ? AM : DATA;
      end
      DATA: begin
        pause_early = seq_last;
        if (!seq_last) begin
          am_cnt_n = am_cnt_q + 1'b1;
          if (am_cnt_q == CNT_LAST) begin
            state_n   = AM;
            am_owed_n = 1'b1;
          end
        end
      end
      AM: begin
        // A marker colliding with the flush slot slips to seq 0
        pause_early = seq_last;
        am_early    = !seq_last;
        if (!seq_last) begin
          am_cnt_n  = '0;
          am_owed_n = 1'b0;
          state_n   = DATA;
        end
      end
      default: state_n = WAIT_EN;
    endcase

    if (state_q != WAIT_EN) begin
      seq_n = seq_last ? '0 : seq_q + 1'b1;
      if (!tx_en_i) state_n = WAIT_EN;
    end
  end

  pcs_delay_line #(
    .WIDTH (SEQ_W + 2),
    .DEPTH (PIPE_LAT)
  ) u_delay_line (
    .clk    (clk),
    .nreset (nreset),
    .din    ({seq_q, pause_early, am_early}),
    .dout   (dl_out)
  );

  assign seq_o      = dl_out[SEQ_W+1:2];
  assign gb_pause_o = dl_out[1];
  assign am_v_o     = dl_out[0];
  assign ready_o    = ready_q;
  assign am_cnt_o   = am_cnt_q;

endmodule
